// File: rtl/uart_tx_fifo_reader.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_reader
//
// UART transmitter that pulls characters from an upstream synchronous FIFO
// (combinational read port: head data valid whenever not empty, popped by a
// one-cycle read strobe) and serialises them onto TXo.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional parity bit,
// STOP_BITS stop bits. Every bit lasts CLKS_PER_BIT clock cycles.
//
// Ports:
//   CLKip   in   system clock
//   RSTi    in   asynchronous active-high reset
//   ENi     in   transmit enable; only gates fetching of new characters
//   EMPTYi  in   upstream FIFO empty flag
//   DATAi   in   upstream FIFO head data
//   RDo     out  FIFO pop strobe (one cycle per character)
//   TXo     out  serial line, idle high, registered
//   BUSYo   out  high from start bit through the last stop bit
//   DONEo   out  one-cycle pulse in the idle cycle that ends a frame
// ---------------------------------------------------------------------------
module uart_tx_fifo_reader #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  CLKip,
    input  logic                  RSTi,
    input  logic                  ENi,
    input  logic                  EMPTYi,
    input  logic [DATA_WIDTH-1:0] DATAi,
    output logic                  RDo,
    output logic                  TXo,
    output logic                  BUSYo,
    output logic                  DONEo
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic              ODD_SEED  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_q,  state_d;
    logic [BAUD_W-1:0]       baud_q,   baud_d;
    logic [IDX_W-1:0]        idx_q,    idx_d;
    logic [DATA_WIDTH-1:0]   shift_q,  shift_d;
    logic                    parity_q, parity_d;
    logic                    tx_q,     tx_d;
    logic                    busy_q,   busy_d;
    logic                    done_q,   done_d;

    logic pop;
    logic bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    // Fetch is only possible from IDLE, so the pop strobe can never fire
    // while a frame is in flight.
    assign pop = (state_q == S_IDLE) && ENi && !EMPTYi;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        // Baud counter sits at zero in IDLE so each frame starts with a full
        // start-bit period.
        if (state_q == S_IDLE || bit_end) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d  = S_START;
                    shift_d  = DATAi;
                    parity_d = (^DATAi) ^ ODD_SEED;
                    idx_d    = '0;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = S_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                        // Next data bit goes out at the same edge the
                        // shift happens, keeping TXo purely registered.
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    idx_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLKip or posedge RSTi) begin
        if (RSTi) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // The state register is cleared asynchronously, but the strobe is also
    // gated directly so it is low for the whole time reset is held.
    assign RDo   = pop && !RSTi;
    assign TXo   = tx_q;
    assign BUSYo = busy_q;
    assign DONEo = done_q;

endmodule

// File: doc/uart_tx_fifo_reader.md
Name: uart_tx_fifo_reader

Overview:
UART transmitter that drains bytes from an upstream synchronous FIFO and serializes them onto TXo. Frame format: 8N1 by default, with optional parity and 2 stop bits. The FIFO has a combinational read port (data valid whenever not empty, popped by a one-cycle read strobe). The block sits on the system-to-line side, mirroring the receive path.

Parameters:
DATA_WIDTH, 8, bits per character (5..9)
CLKS_PER_BIT, 868, CLKip cycles per bit period (100 MHz / 115200); must be >= 2
PARITY_EN, 0, 1 = append parity bit after data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
CLKip  input  1  system clock
RSTi  input  1  asynchronous active-high reset
ENi  input  1  transmit enable; gates fetching of new bytes only
EMPTYi  input  1  upstream FIFO empty flag
DATAi  input  DATA_WIDTH  upstream FIFO head data (combinational read)
RDo  output  1  FIFO pop strobe
TXo  output  1  serial line, idle high
BUSYo  output  1  frame in progress
DONEo  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset: asynchronous, active-high. While RSTi is high: state=IDLE, TXo=1, BUSYo=0, DONEo=0, RDo=0 (RDo is explicitly gated by RSTi). Counters clear.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - RDo = ENi && !EMPTYi, combinational; high for exactly one cycle per byte.
  - On that edge, DATAi is latched into the shift register, the parity bit is computed and latched, and the state moves to START.
  - TXo=1, BUSYo=0.
- START: TXo=0 for CLKS_PER_BIT cycles. BUSYo=1 from START through STOP.
- DATA: DATA_WIDTH bits, LSB first, each held CLKS_PER_BIT cycles.
- PARITY (only if PARITY_EN=1):
  - Even: bit = XOR of the data bits.
  - Odd: bit = inverted XOR.
  - Held CLKS_PER_BIT cycles.
- STOP: TXo=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Completion: after the last stop cycle, return to IDLE with DONEo=1 for that single IDLE cycle.
- TXo is a registered output and must be glitch-free.
- Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1; wraps to 0 on each bit boundary.
- Bit index counter: width $clog2(DATA_WIDTH+1).
- Frame length, measured from TXo falling edge to the return to IDLE: (1+DATA_WIDTH+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
- Back-to-back bytes:
  - Next pop occurs in the DONEo cycle if ENi && !EMPTYi.
  - Consecutive start-bit falling edges are spaced exactly frame_length+1 cycles apart.
- ENi deasserted mid-frame: the current frame completes unchanged; no further pops.
- EMPTYi / DATAi are sampled only in IDLE; changes outside IDLE are ignored.
- Reset mid-frame: TXo goes to 1 immediately (asynchronous) and the frame is abandoned. The popped byte is lost; no DONEo.
- RDo is never asserted while BUSYo=1, so the FIFO cannot underflow.

Test Plan:
1. Reset and idle. Bench: CLKS_PER_BIT=4. Assert RSTi with EMPTYi=0, ENi=1 -> RDo=0, TXo=1, BUSYo=0, DONEo=0 throughout. Release with EMPTYi=1 -> no RDo, TXo stays 1.
2. Single 0x55, 8N1:
   - RDo high for 1 cycle.
   - TXo = 0 (4 cycles), then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 (4 cycles).
   - DONEo pulses exactly 40 cycles after the TXo falling edge.
   - BUSYo is high for 40 cycles.
3. Parity:
   - PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1 and a 44-cycle frame.
   - PARITY_ODD=1, byte 0x07 -> parity bit 0.
   - PARITY_ODD=1, byte 0x00 -> parity bit 1.
4. Back-to-back: FIFO preloaded with 0xA5, 0x3C, 0xFF, ENi=1 -> three RDo pulses. Start-bit falling edges are 41 cycles apart. Decoded bytes match in order. After the third DONEo, EMPTYi=1 and TXo stays 1.
5. Enable gating and STOP_BITS=2:
   - Drop ENi during the data bits of 0x3C -> frame completes; no further RDo while ENi=0.
   - Restore ENi -> next byte is sent.
   - With STOP_BITS=2 -> stop high for 8 cycles and a 44-cycle frame.
6. Reset mid-frame: assert RSTi during data bit 3 of 0xA5 -> TXo=1 and BUSYo=0 in the same cycle, no DONEo. After release with a non-empty FIFO -> a clean new frame starts with a fresh 4-cycle start bit.
